// File: rtl/run_mode_ctrl.sv
// Run-mode sequencer for the JPEG-LS encoder: counts run pixels against the
// J[] table, emits segment/end events and hands interruption samples onward.
module run_mode_ctrl #(
  parameter int PIX_W = 9,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic                    start_run,
  input  logic                    eol,
  input  logic signed [PIX_W-1:0] Ra,
  input  logic signed [PIX_W-1:0] Rb,
  input  logic signed [PIX_W-1:0] Ix,
  output logic                    run_active,
  output logic                    run_seg_valid,
  output logic                    run_end_valid,
  output logic                    run_end_eol,
  output logic [CNT_W-1:0]        run_rem,
  output logic [4:0]              run_rem_bits,
  output logic [4:0]              run_index,
  output logic                    ri_en,
  output logic signed [PIX_W-1:0] ri_Ra,
  output logic signed [PIX_W-1:0] ri_Rb,
  output logic signed [PIX_W-1:0] ri_Ix
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             eval;
  logic             match;
  logic             seg_hit;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   seg_len;
  logic [4:0]       j_cur;
  logic [4:0]       idx_up;
  logic [4:0]       idx_down;

  // J[] = 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,...,15
  function automatic logic [4:0] j_of(input logic [4:0] i);
    if (!i[4])        return {3'b000, i[3:2]};
    else if (!i[3])   return 5'd4 + {3'b000, i[2:1]};
    else              return i - 5'd16;
  endfunction

  // NOTE: every signal written here gets a value first so no latch is inferred.
  always_comb begin
    eval     = pix_valid & ((state == RUN) | start_run);
    match    = (Ix == Ra);
    j_cur    = j_of(run_index);
    cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
    seg_len  = (CNT_W+1)'(1) << j_cur;
    seg_hit  = (cnt_inc == seg_len);
    idx_up   = (seg_hit && run_index != 5'd31) ? run_index + 5'd1 : run_index;
    idx_down = (run_index != 5'd0) ? run_index - 5'd1 : run_index;
  end

  assign run_active = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      run_index     <= '0;
      run_seg_valid <= 1'b0;
      run_end_valid <= 1'b0;
      run_end_eol   <= 1'b0;
      run_rem       <= '0;
      run_rem_bits  <= '0;
      ri_en         <= 1'b0;
      ri_Ra         <= '0;
      ri_Rb         <= '0;
      ri_Ix         <= '0;
    end else begin
      run_seg_valid <= 1'b0;
      run_end_valid <= 1'b0;
      run_end_eol   <= 1'b0;
      ri_en         <= 1'b0;
      if (frame_start) begin
        state     <= IDLE;
        cnt       <= '0;
        run_index <= '0;
      end else if (eval) begin
        if (match) begin
          run_seg_valid <= seg_hit;
          run_index     <= idx_up;
          if (eol) begin
            state <= IDLE;
            cnt   <= '0;
            // A residual exists only when no segment closed; then idx is unchanged.
            if (!seg_hit) begin
              run_end_valid <= 1'b1;
              run_end_eol   <= 1'b1;
              run_rem       <= cnt_inc[CNT_W-1:0];
              run_rem_bits  <= j_cur;
            end
          end else begin
            state <= RUN;
            cnt   <= seg_hit ? '0 : cnt_inc[CNT_W-1:0];
          end
        end else begin
          state         <= IDLE;
          cnt           <= '0;
          run_index     <= idx_down;
          run_end_valid <= 1'b1;
          run_rem       <= cnt;
          run_rem_bits  <= j_cur;
          ri_en         <= 1'b1;
          ri_Ra         <= Ra;
          ri_Rb         <= Rb;
          ri_Ix         <= Ix;
        end
      end
    end
  end

endmodule

// File: doc/run_mode_ctrl.md
Name: run_mode_ctrl

Overview:
Run-mode sequencer for the LOCO-I/JPEG-LS encoder. It counts run pixels while Ix equals Ra and tracks RUNindex with the J[] table. It emits run-segment and run-end events to the bit packer. When a run is broken, it issues a one-cycle enable plus registered Ra/Rb/Ix to the run-interruption error block (Errval/RItype stage).

Parameters:
PIX_W, 9, pixel sample width (signed, matches Errval datapath)
CNT_W, 16, width of run counter / remainder output

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
frame_start  in  1  sync clear at frame start: RUNindex, count, state
pix_valid  in  1  pixel qualifier (Ra, Rb, Ix, eol, start_run valid)
start_run  in  1  context logic selected run mode for this pixel (all gradients zero)
eol  in  1  pixel is last in its line
Ra  in  PIX_W  left neighbour (signed)
Rb  in  PIX_W  upper neighbour (signed)
Ix  in  PIX_W  current sample (signed)
run_active  out  1  state==RUN
run_seg_valid  out  1  pulse: emit one '1' bit (full 2^J segment)
run_end_valid  out  1  pulse: run terminated
run_end_eol  out  1  with run_end_valid: 1=EOL termination, 0=interruption
run_rem  out  CNT_W  residual run count at termination
run_rem_bits  out  5  J[RUNindex] at termination (bits for run_rem)
run_index  out  5  current RUNindex
ri_en  out  1  enable pulse to run-interruption error block
ri_Ra, ri_Rb, ri_Ix  out  PIX_W each  registered samples for that block

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0; RUNindex=0; cnt=0.
- J table, idx 0..31: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15.
- States: IDLE, RUN. A pixel is evaluated if (IDLE & pix_valid & start_run) or (RUN & pix_valid). Other cycles: counters hold; pulse outputs return to 0.
- All outputs registered. Latency is 1 cycle from the evaluated pixel to its pulses.
- Match (Ix==Ra, full PIX_W compare):
  - cnt+1 == 2^J[idx]: run_seg_valid=1, cnt<=0, idx<=min(idx+1,31).
  - Otherwise cnt<=cnt+1.
  - State goes to RUN.
- Match with eol:
  - Apply the segment rule above first.
  - If the resulting cnt>0: run_end_valid=1, run_end_eol=1, run_rem=that cnt, run_rem_bits=J[idx after the segment rule].
  - If cnt=0: no end pulse.
  - In both cases cnt<=0, idx retained, state goes to IDLE.
  - run_seg_valid and run_end_valid may assert in the same cycle. The packer handles the segment first.
- Mismatch (Ix!=Ra), eol irrelevant:
  - run_end_valid=1, run_end_eol=0, run_rem=cnt, run_rem_bits=J[idx].
  - ri_en=1; ri_Ra/ri_Rb/ri_Ix <= Ra/Rb/Ix.
  - Then idx<=max(idx-1,0), cnt<=0, state goes to IDLE.
- ri_* hold their last value when ri_en=0.
- Overflow protection: cnt never exceeds 2^15-1 (bounded by J max 15). CNT_W must be >=15.
- frame_start has priority over any pixel in the same cycle: the pixel is ignored, state goes to IDLE, idx=0, cnt=0, pulses=0.
- RUNindex persists across lines and runs; only reset or frame_start clears it.
- pix_valid gaps during RUN: state, cnt and idx hold indefinitely.
- Asynchronous reset mid-run aborts with no end pulse.

Test Plan:
- Reset then idle -> all outputs 0, run_index=0, run_active=0.
- start_run + 3 matches (Ix=Ra=50) then mismatch Ix=60, Ra=50, Rb=70:
  - 3 consecutive run_seg_valid pulses, run_index 1,2,3.
  - Then run_end_eol=0, run_rem=0, run_rem_bits=0, ri_en=1, ri_Ix=60, ri_Ra=50, ri_Rb=70.
  - run_index becomes 2.
- From run_index=4 (J=1): 2 matches -> one seg pulse, index 5. Then 1 match with eol -> run_end_eol=1, run_rem=1, run_rem_bits=1, index stays 5, state IDLE.
- start_run pixel mismatching at run_index=0 -> run_end with run_rem=0, ri_en=1, run_index stays 0 (no underflow).
- Run with pix_valid low for 5 cycles mid-run -> no pulses, count/index unchanged; run resumes correctly.
- frame_start asserted with a valid matching pixel at run_index=6 -> no pulses, run_index=0, run_active=0.
